// File: rtl/cpu_controller_pkg.sv
// Shared types and encodings for the 16-bit CPU controller.
// Also used by the datapath and memory interface.
package cpu_controller_pkg;

    localparam int STATE_W = 5;

    typedef enum logic [STATE_W-1:0] {
        S_RST, S_IF1, S_IF2, S_UPC, S_DEC,
        S_WIMM, S_GETA, S_GETB, S_ALU, S_WRC,
        S_ADDR, S_LADDR, S_MRD, S_WMEM,
        S_GETRD, S_PASS, S_MWR,
        S_BLW, S_BR, S_BXB, S_BXC, S_BXP,
        S_HALT
    } state_t;

    localparam logic [2:0] OPC_B    = 3'b001;
    localparam logic [2:0] OPC_BL   = 3'b010;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_MVN  = 2'b11;
    localparam logic [1:0] OP_MEM  = 2'b00;
    localparam logic [1:0] OP_B    = 2'b00;
    localparam logic [1:0] OP_BL   = 2'b11;
    localparam logic [1:0] OP_BX   = 2'b00;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_LE = 3'b100;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [3:0] VSEL_C     = 4'b0001;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_IMM   = 4'b0100;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [1:0] PC_SEL_INC = 2'b00;
    localparam logic [1:0] PC_SEL_REL = 2'b01;
    localparam logic [1:0] PC_SEL_REG = 2'b10;
    localparam logic [1:0] PC_SEL_RST = 2'b11;

    typedef struct packed {
        logic [2:0] nsel;
        logic [3:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       write;
        logic       load_ir;
        logic       load_pc;
        logic [1:0] pc_sel;
        logic       load_addr;
        logic       addr_sel;
        logic [1:0] mem_cmd;
        logic       halted;
    } ctrl_t;

    // ALU-state flavour depends on the held instruction, never on flags.
    function automatic ctrl_t ctrl_of(state_t s, logic [2:0] opcode,
                                      logic [1:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_RST:   begin c.load_pc = 1'b1; c.pc_sel = PC_SEL_RST; end
            S_IF1:   begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; end
            S_IF2:   begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MEM_READ;
                c.load_ir  = 1'b1;
            end
            S_UPC:   begin c.load_pc = 1'b1; c.pc_sel = PC_SEL_INC; end
            S_WIMM:  begin
                c.nsel = NSEL_RN; c.vsel = VSEL_IMM; c.write = 1'b1;
            end
            S_GETA:  begin c.nsel = NSEL_RN; c.loada = 1'b1; end
            S_GETB:  begin c.nsel = NSEL_RM; c.loadb = 1'b1; end
            S_ALU:   begin
                c.loadc = 1'b1;
                c.asel  = (opcode == OPC_MOV && op == OP_MOVR)
                       || (opcode == OPC_ALU && op == OP_MVN);
                c.loads = (opcode == OPC_ALU && op == OP_CMP);
            end
            S_WRC:   begin
                c.nsel = NSEL_RD; c.vsel = VSEL_C; c.write = 1'b1;
            end
            S_ADDR:  begin c.bsel = 1'b1; c.loadc = 1'b1; end
            S_LADDR: c.load_addr = 1'b1;
            S_MRD:   c.mem_cmd = MEM_READ;
            S_WMEM:  begin
                c.mem_cmd = MEM_READ;
                c.nsel    = NSEL_RD;
                c.vsel    = VSEL_MDATA;
                c.write   = 1'b1;
            end
            S_GETRD: begin c.nsel = NSEL_RD; c.loadb = 1'b1; end
            S_PASS:  begin c.asel = 1'b1; c.loadc = 1'b1; end
            S_MWR:   c.mem_cmd = MEM_WRITE;
            S_BLW:   begin
                c.nsel = NSEL_RN; c.vsel = VSEL_PC; c.write = 1'b1;
            end
            S_BR:    begin c.load_pc = 1'b1; c.pc_sel = PC_SEL_REL; end
            S_BXB:   begin c.nsel = NSEL_RD; c.loadb = 1'b1; end
            S_BXC:   begin c.asel = 1'b1; c.loadc = 1'b1; end
            S_BXP:   begin c.load_pc = 1'b1; c.pc_sel = PC_SEL_REG; end
            S_HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Decoder/status inputs and control outputs of the CPU controller.
// master = controller side, slave = datapath/memory side.
interface cpu_controller_if;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] cond;
    logic       N;
    logic       V;
    logic       Z;
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       write;
    logic       load_ir;
    logic       load_pc;
    logic [1:0] pc_sel;
    logic       load_addr;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       halted;

    modport master (
        input  opcode, op, cond, N, V, Z,
        output nsel, vsel, loada, loadb, loadc, loads, asel, bsel,
        output write, load_ir, load_pc, pc_sel, load_addr, addr_sel,
        output mem_cmd, halted
    );

    modport slave (
        output opcode, op, cond, N, V, Z,
        input  nsel, vsel, loada, loadb, loadc, loads, asel, bsel,
        input  write, load_ir, load_pc, pc_sel, load_addr, addr_sel,
        input  mem_cmd, halted
    );
endinterface

// File: rtl/cpu_controller_cond_eval.sv
// Branch condition evaluation from the N/V/Z status flags.
module cpu_controller_cond_eval
    import cpu_controller_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       n,
    input  logic       v,
    input  logic       z,
    output logic       taken
);
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_AL: taken = 1'b1;
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_LT: taken = n ^ v;
            COND_LE: taken = (n ^ v) | z;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/cpu_controller.sv
// Moore FSM sequencing fetch, decode and execute of the 16-bit CPU.
// Outputs are registered from the next state so they line up with it.
module cpu_controller
    import cpu_controller_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input logic              clk,
    input logic              reset,
    cpu_controller_if.master bus
);
    state_t state;
    state_t nxt;
    ctrl_t  ctl;
    logic   taken;

    logic is_movi, is_movr, is_mvn, is_alu;
    logic is_ldr, is_str, is_b, is_bl, is_bx, is_halt;

    cpu_controller_cond_eval u_cond_eval (
        .cond  (bus.cond),
        .n     (bus.N),
        .v     (bus.V),
        .z     (bus.Z),
        .taken (taken)
    );

    assign is_movi = bus.opcode == OPC_MOV && bus.op == OP_MOVI;
    assign is_movr = bus.opcode == OPC_MOV && bus.op == OP_MOVR;
    assign is_mvn  = bus.opcode == OPC_ALU && bus.op == OP_MVN;
    assign is_alu  = bus.opcode == OPC_ALU && bus.op != OP_MVN;
    assign is_ldr  = bus.opcode == OPC_LDR && bus.op == OP_MEM;
    assign is_str  = bus.opcode == OPC_STR && bus.op == OP_MEM;
    assign is_b    = bus.opcode == OPC_B && bus.op == OP_B;
    assign is_bl   = bus.opcode == OPC_BL && bus.op == OP_BL;
    assign is_bx   = bus.opcode == OPC_BL && bus.op == OP_BX;
    assign is_halt = bus.opcode == OPC_HALT;

    always_comb begin
        nxt = S_RST;
        case (state)
            S_RST:   nxt = S_IF1;
            S_IF1:   nxt = S_IF2;
            S_IF2:   nxt = S_UPC;
            S_UPC:   nxt = S_DEC;
            S_DEC: begin
                unique case (1'b1)
                    is_movi:          nxt = S_WIMM;
                    is_movr, is_mvn:  nxt = S_GETB;
                    is_alu:           nxt = S_GETA;
                    is_ldr, is_str:   nxt = S_GETA;
                    is_b:             nxt = taken ? S_BR : S_IF1;
                    is_bl:            nxt = S_BLW;
                    is_bx:            nxt = S_BXB;
                    is_halt:          nxt = S_HALT;
                    default:
                        nxt = HALT_ON_ILLEGAL ? S_HALT : S_IF1;
                endcase
            end
            S_WIMM:  nxt = S_IF1;
            S_GETA:  nxt = (is_ldr || is_str) ? S_ADDR : S_GETB;
            S_GETB:  nxt = S_ALU;
            S_ALU:   nxt = (bus.op == OP_CMP && is_alu) ? S_IF1 : S_WRC;
            S_WRC:   nxt = S_IF1;
            S_ADDR:  nxt = S_LADDR;
            S_LADDR: nxt = is_ldr ? S_MRD : S_GETRD;
            S_MRD:   nxt = S_WMEM;
            S_WMEM:  nxt = S_IF1;
            S_GETRD: nxt = S_PASS;
            S_PASS:  nxt = S_MWR;
            S_MWR:   nxt = S_IF1;
            S_BLW:   nxt = S_BR;
            S_BR:    nxt = S_IF1;
            S_BXB:   nxt = S_BXC;
            S_BXC:   nxt = S_BXP;
            S_BXP:   nxt = S_IF1;
            S_HALT:  nxt = S_HALT;
            default: nxt = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RST;
            ctl   <= ctrl_of(S_RST, bus.opcode, bus.op);
        end else begin
            state <= nxt;
            ctl   <= ctrl_of(nxt, bus.opcode, bus.op);
        end
    end

    assign bus.nsel      = ctl.nsel;
    assign bus.vsel      = ctl.vsel;
    assign bus.loada     = ctl.loada;
    assign bus.loadb     = ctl.loadb;
    assign bus.loadc     = ctl.loadc;
    assign bus.loads     = ctl.loads;
    assign bus.asel      = ctl.asel;
    assign bus.bsel      = ctl.bsel;
    assign bus.write     = ctl.write;
    assign bus.load_ir   = ctl.load_ir;
    assign bus.load_pc   = ctl.load_pc;
    assign bus.pc_sel    = ctl.pc_sel;
    assign bus.load_addr = ctl.load_addr;
    assign bus.addr_sel  = ctl.addr_sel;
    assign bus.mem_cmd   = ctl.mem_cmd;
    assign bus.halted    = ctl.halted;
endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: instruction table, random instructions
// against an instruction-level model, plus reset and halt sequences.
module tb_cpu_controller;

    typedef struct packed {
        logic [2:0] nsel;
        logic [3:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       write;
        logic       load_ir;
        logic       load_pc;
        logic [1:0] pc_sel;
        logic       load_addr;
        logic       addr_sel;
        logic [1:0] mem_cmd;
        logic       halted;
    } ctl_t;

    typedef struct {
        string      name;
        logic [2:0] opc;
        logic [1:0] op;
        logic [2:0] cond;
        logic       n;
        logic       v;
        logic       z;
        int         cyc;
        int         wr;
        int         mw;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    ctl_t exp_q[$];

    cpu_controller_if bus ();

    cpu_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic ctl_t obs();
        ctl_t c;
        c.nsel      = bus.nsel;
        c.vsel      = bus.vsel;
        c.loada     = bus.loada;
        c.loadb     = bus.loadb;
        c.loadc     = bus.loadc;
        c.loads     = bus.loads;
        c.asel      = bus.asel;
        c.bsel      = bus.bsel;
        c.write     = bus.write;
        c.load_ir   = bus.load_ir;
        c.load_pc   = bus.load_pc;
        c.pc_sel    = bus.pc_sel;
        c.load_addr = bus.load_addr;
        c.addr_sel  = bus.addr_sel;
        c.mem_cmd   = bus.mem_cmd;
        c.halted    = bus.halted;
        return c;
    endfunction

    function automatic bit is_if1(ctl_t c);
        return c.addr_sel && c.mem_cmd == 2'b01 && !c.load_ir;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input ctl_t got, input ctl_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc%0d got=%h want=%h", nm, idx, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    function automatic ctl_t k_wr(logic [2:0] ns, logic [3:0] vs);
        ctl_t c;
        c = '0; c.nsel = ns; c.vsel = vs; c.write = 1'b1;
        return c;
    endfunction

    function automatic ctl_t k_pc(logic [1:0] sel);
        ctl_t c;
        c = '0; c.load_pc = 1'b1; c.pc_sel = sel;
        return c;
    endfunction

    function automatic ctl_t k_if1();
        ctl_t c;
        c = '0; c.addr_sel = 1'b1; c.mem_cmd = 2'b01;
        return c;
    endfunction

    // Control events an instruction must produce, cycle by cycle from IF1.
    task automatic model(input logic [2:0] opc, input logic [1:0] op,
                         input logic [2:0] cond,
                         input logic n, input logic v, input logic z);
        ctl_t c;
        bit   taken, mv, alu, cmp, mem;
        taken = (cond == 0) || (cond == 1 && z) || (cond == 2 && !z)
             || (cond == 3 && n != v) || (cond == 4 && (n != v || z));
        mv  = (opc == 3'd6 && op == 2'd0) || (opc == 3'd5 && op == 2'd3);
        alu = opc == 3'd5 && op != 2'd3;
        cmp = opc == 3'd5 && op == 2'd1;
        mem = (opc == 3'd3 || opc == 3'd4) && op == 2'd0;
        exp_q.delete();
        c = k_if1(); exp_q.push_back(c);
        c.load_ir = 1'b1; exp_q.push_back(c);
        exp_q.push_back(k_pc(2'b00));
        c = '0; exp_q.push_back(c);
        if (opc == 3'd6 && op == 2'd2) begin
            exp_q.push_back(k_wr(3'b001, 4'b0100));
        end else if (mv || alu) begin
            c = '0; c.nsel = 3'b001; c.loada = 1'b1;
            if (alu) exp_q.push_back(c);
            c = '0; c.nsel = 3'b100; c.loadb = 1'b1; exp_q.push_back(c);
            c = '0; c.loadc = 1'b1; c.asel = mv; c.loads = cmp;
            exp_q.push_back(c);
            if (!cmp) exp_q.push_back(k_wr(3'b010, 4'b0001));
        end else if (mem) begin
            c = '0; c.nsel = 3'b001; c.loada = 1'b1; exp_q.push_back(c);
            c = '0; c.bsel = 1'b1; c.loadc = 1'b1; exp_q.push_back(c);
            c = '0; c.load_addr = 1'b1; exp_q.push_back(c);
            if (opc == 3'd3) begin
                c = '0; c.mem_cmd = 2'b01; exp_q.push_back(c);
                c = k_wr(3'b010, 4'b1000); c.mem_cmd = 2'b01;
                exp_q.push_back(c);
            end else begin
                c = '0; c.nsel = 3'b010; c.loadb = 1'b1; exp_q.push_back(c);
                c = '0; c.asel = 1'b1; c.loadc = 1'b1; exp_q.push_back(c);
                c = '0; c.mem_cmd = 2'b10; exp_q.push_back(c);
            end
        end else if (opc == 3'd1 && op == 2'd0) begin
            if (taken) exp_q.push_back(k_pc(2'b01));
        end else if (opc == 3'd2 && op == 2'd3) begin
            exp_q.push_back(k_wr(3'b001, 4'b0010));
            exp_q.push_back(k_pc(2'b01));
        end else if (opc == 3'd2 && op == 2'd0) begin
            c = '0; c.nsel = 3'b010; c.loadb = 1'b1; exp_q.push_back(c);
            c = '0; c.asel = 1'b1; c.loadc = 1'b1; exp_q.push_back(c);
            exp_q.push_back(k_pc(2'b10));
        end
    endtask

    // Entered with the DUT sampled in IF1; returns sampled in the next IF1.
    task automatic run_instr(input string nm, input logic [2:0] opc,
                             input logic [1:0] op, input logic [2:0] cond,
                             input logic n, input logic v, input logic z,
                             output int cyc, output int wr, output int mw);
        ctl_t o;
        ctl_t bad;
        bad = '1;
        bus.opcode = opc; bus.op = op; bus.cond = cond;
        bus.N = n; bus.V = v; bus.Z = z;
        model(opc, op, cond, n, v, z);
        cyc = 0; wr = 0; mw = 0;
        o = obs();
        do begin
            chk(nm, cyc, o, cyc < exp_q.size() ? exp_q[cyc] : bad);
            wr += int'(o.write);
            mw += int'(o.mem_cmd == 2'b10);
            cyc++;
            step();
            o = obs();
        end while (!is_if1(o) && cyc < 30);
        if (cyc >= 30) begin
            errors++;
            $display("FAIL %s timeout waiting for IF1", nm);
        end
    endtask

    vec_t tbl[$];

    initial begin
        int   cyc, wr, mw;
        ctl_t c;
        tbl.push_back('{"movi", 3'd6, 2'd2, 3'd0, 0, 0, 0, 5, 1, 0});
        tbl.push_back('{"movr", 3'd6, 2'd0, 3'd0, 0, 0, 0, 7, 1, 0});
        tbl.push_back('{"mvn",  3'd5, 2'd3, 3'd0, 0, 0, 0, 7, 1, 0});
        tbl.push_back('{"add",  3'd5, 2'd0, 3'd0, 0, 0, 0, 8, 1, 0});
        tbl.push_back('{"and",  3'd5, 2'd2, 3'd0, 0, 0, 0, 8, 1, 0});
        tbl.push_back('{"cmp",  3'd5, 2'd1, 3'd0, 1, 0, 1, 7, 0, 0});
        tbl.push_back('{"ldr",  3'd3, 2'd0, 3'd0, 0, 0, 0, 9, 1, 0});
        tbl.push_back('{"str",  3'd4, 2'd0, 3'd0, 0, 0, 0, 10, 0, 1});
        tbl.push_back('{"b",    3'd1, 2'd0, 3'd0, 0, 0, 0, 5, 0, 0});
        tbl.push_back('{"beq0", 3'd1, 2'd0, 3'd1, 0, 0, 0, 4, 0, 0});
        tbl.push_back('{"beq1", 3'd1, 2'd0, 3'd1, 0, 0, 1, 5, 0, 0});
        tbl.push_back('{"bne1", 3'd1, 2'd0, 3'd2, 0, 0, 1, 4, 0, 0});
        tbl.push_back('{"blt",  3'd1, 2'd0, 3'd3, 1, 0, 0, 5, 0, 0});
        tbl.push_back('{"ble",  3'd1, 2'd0, 3'd4, 0, 0, 1, 5, 0, 0});
        tbl.push_back('{"ble0", 3'd1, 2'd0, 3'd4, 1, 1, 0, 4, 0, 0});
        tbl.push_back('{"bnv",  3'd1, 2'd0, 3'd5, 1, 0, 1, 4, 0, 0});
        tbl.push_back('{"bl",   3'd2, 2'd3, 3'd0, 0, 0, 0, 6, 1, 0});
        tbl.push_back('{"bx",   3'd2, 2'd0, 3'd0, 0, 0, 0, 7, 0, 0});
        tbl.push_back('{"ill",  3'd2, 2'd1, 3'd0, 0, 0, 0, 4, 0, 0});
        tbl.push_back('{"ill2", 3'd3, 2'd1, 3'd0, 0, 0, 0, 4, 0, 0});
        tbl.push_back('{"ill3", 3'd6, 2'd1, 3'd0, 0, 0, 0, 4, 0, 0});

        bus.opcode = 3'd0; bus.op = 2'd0; bus.cond = 3'd0;
        bus.N = 1'b0; bus.V = 1'b0; bus.Z = 1'b0;

        step();
        chk("rst_a", 0, obs(), k_pc(2'b11));
        step();
        chk("rst_b", 1, obs(), k_pc(2'b11));
        reset = 1'b0;
        step();

        foreach (tbl[i]) begin
            run_instr(tbl[i].name, tbl[i].opc, tbl[i].op, tbl[i].cond,
                      tbl[i].n, tbl[i].v, tbl[i].z, cyc, wr, mw);
            chk_int({tbl[i].name, "_cycles"}, cyc, tbl[i].cyc);
            chk_int({tbl[i].name, "_writes"}, wr, tbl[i].wr);
            chk_int({tbl[i].name, "_memwr"}, mw, tbl[i].mw);
        end

        for (int i = 0; i < 60; i++) begin
            logic [2:0] ro, rc;
            logic [1:0] rp;
            logic [2:0] f;
            ro = 3'($urandom_range(0, 6));
            rp = 2'($urandom);
            rc = 3'($urandom);
            f  = 3'($urandom);
            run_instr("rand", ro, rp, rc, f[2], f[1], f[0], cyc, wr, mw);
            chk_int("rand_cycles", cyc, exp_q.size());
        end

        // Reset in the ALU state of ADD must drop the pending writeback.
        bus.opcode = 3'd5; bus.op = 2'd0;
        chk("pre_add_if1", 0, obs(), k_if1());
        repeat (6) step();
        c = '0; c.loadc = 1'b1;
        chk("add_alu", 6, obs(), c);
        reset = 1'b1;
        step();
        chk("mid_rst", 7, obs(), k_pc(2'b11));
        reset = 1'b0;
        step();
        chk("mid_rst_if1", 8, obs(), k_if1());

        bus.opcode = 3'd7; bus.op = 2'd0;
        repeat (4) step();
        c = '0; c.halted = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("halt", i, obs(), c);
            step();
        end
        reset = 1'b1;
        step();
        chk("halt_rst", 0, obs(), k_pc(2'b11));
        reset = 1'b0;
        step();
        chk("halt_exit_if1", 0, obs(), k_if1());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
